clk_freq_monitor: RTL

// - Checks the clocking-wizard outputs in the i_sys_clk (100 MHz) domain.
// - Waits for the MMCM lock, lets it settle, then counts rising edges of one generated clock.
//   The count window is repeated and is GATE_CYCLES sys cycles long.
// - Reports each count, a pass/fail frequency flag, and a sticky lock-loss flag.
// - Sits beside clocking_wized_top. The results feed status registers and self-check benches.

---
 rtl/clk_freq_monitor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/clk_freq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clk_freq_monitor
// Summary  : Counts rising edges of a generated clock over repeated sys-clock
//            windows once the MMCM is locked and settled; flags frequency and lock loss.
// Revision : 1.0 - initial release
// ============================================================================
module clk_freq_monitor #(
    parameter int GATE_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 64,
    parameter int EXP_COUNT     = 200,
    parameter int TOL           = 2,
    parameter int CNT_W         = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             i_sys_clk,
    input  logic             i_rst,
    input  logic             i_locked,
    input  logic             i_meas_clk,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count,
    output logic             o_count_valid,
    output logic             o_freq_ok,
    output logic             o_lock_lost
);

    localparam int c_GATE_W = $clog2(GATE_CYCLES);
    localparam int c_SET_W  = $clog2(SETTLE_CYCLES + 1);

    localparam logic [c_GATE_W-1:0]     c_GATE_LAST = c_GATE_W'(GATE_CYCLES - 1);
    localparam logic [c_SET_W-1:0]      c_SET_LAST  = c_SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]        c_CNT_MAX   = '1;
    localparam logic signed [CNT_W+1:0] c_EXP       = (CNT_W+2)'(EXP_COUNT);
    localparam logic signed [CNT_W+1:0] c_TOL       = (CNT_W+2)'(TOL);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_REPORT  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_lock_sync;
    logic [SYNC_STAGES-1:0]  r_meas_sync;
    logic                    r_meas_d;
    logic [c_SET_W-1:0]      r_settle_cnt;
    logic [c_GATE_W-1:0]     r_gate_cnt;
    logic [CNT_W-1:0]        r_edge_cnt;

    logic                    w_locked_s;
    logic                    w_meas_s;
    logic                    w_rise;
    logic                    w_loss;
    logic signed [CNT_W+1:0] w_diff;
    logic signed [CNT_W+1:0] w_abs;
    logic                    w_in_tol;

    assign w_locked_s = r_lock_sync[SYNC_STAGES-1];
    assign w_meas_s   = r_meas_sync[SYNC_STAGES-1];
    assign w_rise     = w_meas_s & ~r_meas_d;
    assign w_loss     = ~w_locked_s && (r_state != S_IDLE);

    // Two guard bits keep the difference from wrapping for any counter value.
    assign w_diff   = $signed({2'b00, r_edge_cnt}) - c_EXP;
    assign w_abs    = (w_diff < 0) ? -w_diff : w_diff;
    assign w_in_tol = (w_abs <= c_TOL);

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_lock_sync   <= '0;
            r_meas_sync   <= '0;
            r_meas_d      <= 1'b0;
            r_settle_cnt  <= '0;
            r_gate_cnt    <= '0;
            r_edge_cnt    <= '0;
            o_count       <= '0;
            o_count_valid <= 1'b0;
            o_freq_ok     <= 1'b0;
            o_lock_lost   <= 1'b0;
        end else begin
            r_lock_sync   <= {r_lock_sync[SYNC_STAGES-2:0], i_locked};
            r_meas_sync   <= {r_meas_sync[SYNC_STAGES-2:0], i_meas_clk};
            r_meas_d      <= w_meas_s;
            o_count_valid <= 1'b0;

            // A fresh loss takes priority over a simultaneous clear.
            if (w_loss) begin
                o_lock_lost <= 1'b1;
            end else if (i_clear) begin
                o_lock_lost <= 1'b0;
            end

            if (w_loss) begin
                r_state   <= S_IDLE;
                o_freq_ok <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_locked_s) begin
                            r_settle_cnt <= '0;
                            r_state      <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (r_settle_cnt == c_SET_LAST) begin
                            r_gate_cnt <= '0;
                            r_edge_cnt <= '0;
                            r_state    <= S_MEASURE;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 1'b1;
                        end
                    end
                    S_MEASURE: begin
                        if (w_rise && (r_edge_cnt != c_CNT_MAX)) begin
                            r_edge_cnt <= r_edge_cnt + 1'b1;
                        end
                        if (r_gate_cnt == c_GATE_LAST) begin
                            r_state <= S_REPORT;
                        end else begin
                            r_gate_cnt <= r_gate_cnt + 1'b1;
                        end
                    end
                    S_REPORT: begin
                        o_count       <= r_edge_cnt;
                        o_count_valid <= 1'b1;
                        o_freq_ok     <= w_in_tol;
                        r_gate_cnt    <= '0;
                        r_edge_cnt    <= '0;
                        r_state       <= S_MEASURE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
